// File: rtl/prepare_eng_ctrl.sv
// Control FSM for the VR replica Prepare/ValidateRead engine.
// Sequences one inbound message at a time through the VR-state read,
// the accept checks, the clean-entry header read, the payload writes,
// the log-header/VR-state commit and the response to the UDP path.
//
// state         | meaning
// --------------+-------------------------------------------------------
// IDLE          | ready for a header beat; latch header into datapath
// ST_RD_REQ     | issue VR-state read request
// ST_RD_RESP    | wait for VR-state read data
// CHECK         | one cycle: capture response, decide accept/drop
// CLEAN_RD_REQ  | issue clean-entry log-header read request
// CLEAN_RD_RESP | wait for clean-entry header, store it in datapath
// LOG_DATA      | forward payload beats into the log data memory
// DRAIN         | discard remaining payload beats
// COMMIT        | write log header and VR state (independent handshakes)
// RESP_TX       | send response meta and data line (independent handshakes)
module prepare_eng_ctrl (
    input  logic clk,
    input  logic rst_n,

    input  logic manage_prep_req_val,
    input  logic manage_prep_req_last,
    output logic prep_manage_req_rdy,

    output logic prep_state_rd_req_val,
    input  logic state_prep_rd_req_rdy,
    input  logic state_prep_rd_resp_val,
    output logic prep_state_rd_resp_rdy,
    output logic prep_state_wr_val,
    input  logic state_prep_wr_rdy,

    output logic prep_log_hdr_rd_req_val,
    input  logic log_hdr_prep_rd_req_rdy,
    input  logic log_hdr_prep_rd_resp_val,
    output logic prep_log_hdr_rd_resp_rdy,
    output logic prep_log_hdr_wr_val,
    input  logic log_hdr_prep_wr_rdy,

    output logic prep_log_data_wr_val,
    input  logic log_data_prep_wr_rdy,

    output logic prep_to_udp_meta_val,
    input  logic udp_to_prep_meta_rdy,
    output logic prep_to_udp_data_val,
    output logic prep_to_udp_data_last,
    input  logic udp_to_prep_data_rdy,

    output logic ctrl_datap_store_info,
    output logic ctrl_datap_store_resp,
    output logic log_ctrl_datap_incr_wr_addr,
    output logic clean_ctrl_datap_store_hdr,

    input  logic datap_ctrl_prep_ok,
    input  logic datap_ctrl_log_has_space,
    input  logic datap_ctrl_msg_is_validate
);

    typedef enum logic [3:0] {
        IDLE,
        ST_RD_REQ,
        ST_RD_RESP,
        CHECK,
        CLEAN_RD_REQ,
        CLEAN_RD_RESP,
        LOG_DATA,
        DRAIN,
        COMMIT,
        RESP_TX
    } state_e;

    state_e state_q, state_d;
    logic   more_beats_q, more_beats_d;
    logic   send_resp_q, send_resp_d;
    logic   hdr_done_q, hdr_done_d;
    logic   st_done_q, st_done_d;
    logic   meta_done_q, meta_done_d;
    logic   data_done_q, data_done_d;

    logic   hdr_now, st_now, meta_now, data_now;

    // State register and per-message flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            more_beats_q <= 1'b0;
            send_resp_q  <= 1'b0;
            hdr_done_q   <= 1'b0;
            st_done_q    <= 1'b0;
            meta_done_q  <= 1'b0;
            data_done_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            more_beats_q <= more_beats_d;
            send_resp_q  <= send_resp_d;
            hdr_done_q   <= hdr_done_d;
            st_done_q    <= st_done_d;
            meta_done_q  <= meta_done_d;
            data_done_q  <= data_done_d;
        end
    end

    // Next-state, flag updates and all handshake/strobe outputs.
    always_comb begin
        state_d      = state_q;
        more_beats_d = more_beats_q;
        send_resp_d  = send_resp_q;
        hdr_done_d   = hdr_done_q;
        st_done_d    = st_done_q;
        meta_done_d  = meta_done_q;
        data_done_d  = data_done_q;

        prep_manage_req_rdy         = 1'b0;
        prep_state_rd_req_val       = 1'b0;
        prep_state_rd_resp_rdy      = 1'b0;
        prep_state_wr_val           = 1'b0;
        prep_log_hdr_rd_req_val     = 1'b0;
        prep_log_hdr_rd_resp_rdy    = 1'b0;
        prep_log_hdr_wr_val         = 1'b0;
        prep_log_data_wr_val        = 1'b0;
        prep_to_udp_meta_val        = 1'b0;
        prep_to_udp_data_val        = 1'b0;
        prep_to_udp_data_last       = 1'b0;
        ctrl_datap_store_info       = 1'b0;
        ctrl_datap_store_resp       = 1'b0;
        log_ctrl_datap_incr_wr_addr = 1'b0;
        clean_ctrl_datap_store_hdr  = 1'b0;

        hdr_now  = 1'b0;
        st_now   = 1'b0;
        meta_now = 1'b0;
        data_now = 1'b0;

        unique case (state_q)
            IDLE: begin
                prep_manage_req_rdy = 1'b1;
                if (manage_prep_req_val) begin
                    ctrl_datap_store_info = 1'b1;
                    more_beats_d          = ~manage_prep_req_last;
                    send_resp_d           = 1'b0;
                    state_d               = ST_RD_REQ;
                end
            end
            ST_RD_REQ: begin
                prep_state_rd_req_val = 1'b1;
                if (state_prep_rd_req_rdy) begin
                    state_d = ST_RD_RESP;
                end
            end
            ST_RD_RESP: begin
                prep_state_rd_resp_rdy = 1'b1;
                if (state_prep_rd_resp_val) begin
                    state_d = CHECK;
                end
            end
            CHECK: begin
                // Response is captured before any commit touches VR state.
                ctrl_datap_store_resp = 1'b1;
                if (datap_ctrl_msg_is_validate) begin
                    send_resp_d = 1'b1;
                    state_d     = more_beats_q ? DRAIN : RESP_TX;
                end else if (datap_ctrl_prep_ok && datap_ctrl_log_has_space) begin
                    send_resp_d = 1'b1;
                    state_d     = CLEAN_RD_REQ;
                end else if (!datap_ctrl_prep_ok) begin
                    send_resp_d = 1'b1;
                    state_d     = more_beats_q ? DRAIN : RESP_TX;
                end else begin
                    // Log full: drop silently and let the primary retransmit.
                    send_resp_d = 1'b0;
                    state_d     = more_beats_q ? DRAIN : IDLE;
                end
            end
            CLEAN_RD_REQ: begin
                prep_log_hdr_rd_req_val = 1'b1;
                if (log_hdr_prep_rd_req_rdy) begin
                    state_d = CLEAN_RD_RESP;
                end
            end
            CLEAN_RD_RESP: begin
                prep_log_hdr_rd_resp_rdy = 1'b1;
                if (log_hdr_prep_rd_resp_val) begin
                    clean_ctrl_datap_store_hdr = 1'b1;
                    state_d = more_beats_q ? LOG_DATA : COMMIT;
                end
            end
            LOG_DATA: begin
                prep_log_data_wr_val = manage_prep_req_val;
                prep_manage_req_rdy  = log_data_prep_wr_rdy;
                if (manage_prep_req_val && log_data_prep_wr_rdy) begin
                    log_ctrl_datap_incr_wr_addr = 1'b1;
                    if (manage_prep_req_last) begin
                        state_d = COMMIT;
                    end
                end
            end
            DRAIN: begin
                prep_manage_req_rdy = 1'b1;
                if (manage_prep_req_val && manage_prep_req_last) begin
                    state_d = send_resp_q ? RESP_TX : IDLE;
                end
            end
            COMMIT: begin
                prep_log_hdr_wr_val = ~hdr_done_q;
                prep_state_wr_val   = ~st_done_q;
                hdr_now = hdr_done_q | log_hdr_prep_wr_rdy;
                st_now  = st_done_q  | state_prep_wr_rdy;
                if (hdr_now && st_now) begin
                    hdr_done_d = 1'b0;
                    st_done_d  = 1'b0;
                    state_d    = RESP_TX;
                end else begin
                    hdr_done_d = hdr_now;
                    st_done_d  = st_now;
                end
            end
            RESP_TX: begin
                prep_to_udp_meta_val  = ~meta_done_q;
                prep_to_udp_data_val  = ~data_done_q;
                prep_to_udp_data_last = ~data_done_q;
                meta_now = meta_done_q | udp_to_prep_meta_rdy;
                data_now = data_done_q | udp_to_prep_data_rdy;
                if (meta_now && data_now) begin
                    meta_done_d = 1'b0;
                    data_done_d = 1'b0;
                    state_d     = IDLE;
                end else begin
                    meta_done_d = meta_now;
                    data_done_d = data_now;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: doc/prepare_eng_ctrl.md
# prepare_eng_ctrl

Control FSM for the VR replica's Prepare/ValidateRead engine. It takes one message at a time from the manage stage and sequences every step for that message: the VR-state read, the accept checks, the log-cleaning header read, payload writes into the log data memory, and the log-header and VR-state commit. It also emits the PrepareOK or ValidateReadReply to the UDP transmit path. It drives the `ctrl_datap_*`, `log_ctrl_datap_incr_wr_addr` and `clean_ctrl_datap_store_hdr` strobes of `prepare_datap` and consumes its `datap_ctrl_*` status.

## Interface
- No parameters. Widths are fixed by `beehive_vr_pkg`.
- `clk` in 1 — clock.
- `rst_n` in 1 — asynchronous, active-low reset.
- `manage_prep_req_val` / `manage_prep_req_last` in 1 — inbound beat valid; last beat of message.
- `prep_manage_req_rdy` out 1 — inbound beat accepted.
- `prep_state_rd_req_val` out 1 / `state_prep_rd_req_rdy` in 1 — VR-state read request.
- `state_prep_rd_resp_val` in 1 / `prep_state_rd_resp_rdy` out 1 — VR-state read response.
- `prep_state_wr_val` out 1 / `state_prep_wr_rdy` in 1 — VR-state write.
- `prep_log_hdr_rd_req_val` out 1 / `log_hdr_prep_rd_req_rdy` in 1 — clean-entry header read request.
- `log_hdr_prep_rd_resp_val` in 1 / `prep_log_hdr_rd_resp_rdy` out 1 — clean-entry header read response.
- `prep_log_hdr_wr_val` out 1 / `log_hdr_prep_wr_rdy` in 1 — log-header write.
- `prep_log_data_wr_val` out 1 / `log_data_prep_wr_rdy` in 1 — payload line write.
- `prep_to_udp_meta_val` out 1 / `udp_to_prep_meta_rdy` in 1 — response metadata.
- `prep_to_udp_data_val` / `prep_to_udp_data_last` out 1 / `udp_to_prep_data_rdy` in 1 — response line.
- `ctrl_datap_store_info`, `ctrl_datap_store_resp`, `log_ctrl_datap_incr_wr_addr`, `clean_ctrl_datap_store_hdr` out 1 — datapath strobes.
- `datap_ctrl_prep_ok`, `datap_ctrl_log_has_space`, `datap_ctrl_msg_is_validate` in 1 — datapath status.

## Operation
- States: IDLE, ST_RD_REQ, ST_RD_RESP, CHECK, CLEAN_RD_REQ, CLEAN_RD_RESP, LOG_DATA, DRAIN, COMMIT, RESP_TX.
- IDLE
  - `prep_manage_req_rdy` = 1.
  - On `manage_prep_req_val`: pulse `ctrl_datap_store_info`, consume the header beat, capture `more_beats` = ~`manage_prep_req_last`, go to ST_RD_REQ.
- ST_RD_REQ: assert `prep_state_rd_req_val`; on rdy go to ST_RD_RESP.
- ST_RD_RESP: `prep_state_rd_resp_rdy` = 1; on val go to CHECK. Read data is held by the state memory until the next request.
- CHECK (exactly one cycle):
  - Pulse `ctrl_datap_store_resp`, so the response reflects pre-commit state.
  - Validate → `send_resp` = 1; go to DRAIN if `more_beats`, else RESP_TX.
  - Prepare with prep_ok & has_space → `send_resp` = 1, go to CLEAN_RD_REQ.
  - Prepare with ~prep_ok → `send_resp` = 1, go to DRAIN (or RESP_TX if no beats).
  - Prepare with prep_ok & ~has_space → `send_resp` = 0, go to DRAIN (or IDLE). The message is dropped silently; the primary retransmits.
- CLEAN_RD_REQ → CLEAN_RD_RESP: same read handshake on the log-header memory. On resp val, pulse `clean_ctrl_datap_store_hdr`, then go to LOG_DATA if `more_beats`, else COMMIT.
- LOG_DATA
  - `prep_log_data_wr_val` = `manage_prep_req_val`; `prep_manage_req_rdy` = `log_data_prep_wr_rdy`.
  - On each transfer (both high), pulse `log_ctrl_datap_incr_wr_addr`.
  - Transfer with last → COMMIT.
- DRAIN: `prep_manage_req_rdy` = 1, beats discarded; on last go to RESP_TX if `send_resp`, else IDLE.
- COMMIT
  - Assert `prep_log_hdr_wr_val` and `prep_state_wr_val` together.
  - Each deasserts after its own handshake (done flags `hdr_done`, `st_done`).
  - When both are done, clear the flags and go to RESP_TX.
- RESP_TX
  - Assert meta val and data val (`prep_to_udp_data_last` = 1) independently, each with its own done flag.
  - When both are done, go to IDLE.
- Only one message is in flight. `prep_manage_req_rdy` = 0 in every state except IDLE, LOG_DATA and DRAIN.

## Timing
- Reset (async assert, sync-safe deassert): state = IDLE; all done flags, `more_beats` and `send_resp` cleared.
- All val and strobe outputs are 0 in reset, except `prep_manage_req_rdy`, which is 1 (combinational in IDLE).
- All outputs are combinational from state, flags and inputs; strobes last one cycle.
- `rst_n` asserted mid-message abandons it with no partial commit, unless COMMIT handshakes already completed. Any remaining payload beats are then treated as headers of new messages; upstream must be reset together with this block.
- Minimum latency, single-beat Prepare, all rdys = 1, read responses next cycle: IDLE accept t0 → ST_RD_REQ t1 → ST_RD_RESP t2 → CHECK t3 → CLEAN_RD_REQ t4 → CLEAN_RD_RESP t5 → COMMIT t6 → RESP_TX t7 → IDLE t8.
- N payload beats at full rate add N cycles in LOG_DATA.
- A val may not drop before its rdy. Meta and data may complete in either order or in the same cycle.

## Test plan
- Single-beat ValidateRead, all rdy = 1 → one `ctrl_datap_store_resp` at t3; meta+data handshake at t4; `prep_log_hdr_wr_val` and `prep_state_wr_val` never asserted.
- Prepare, 4 beats (header + 3 payload), prep_ok = 1, has_space = 1 → exactly 3 `log_ctrl_datap_incr_wr_addr` pulses, 1 `clean_ctrl_datap_store_hdr`, 1 commit of both writes, then the response.
- Same Prepare with `log_data_prep_wr_rdy` toggling 1,0,0,1,1 → `prep_manage_req_rdy` mirrors it; increments only on transfers, still 3 total.
- Prepare with prep_ok = 0, 3 payload beats → 3 beats drained, no writes, response sent; has_space = 0 → drained, no response, back to IDLE.
- COMMIT with `state_prep_wr_rdy` late by 5 cycles and `log_hdr_prep_wr_rdy` immediate → hdr val drops after 1 cycle, state val held 6 cycles, exactly one write each.
- `rst_n` pulled low during LOG_DATA after 1 beat → all vals 0 immediately, state IDLE, no `prep_state_wr_val` issued.
